// File: rtl/nn_pkg.sv
// Shared types and default sizing for the input buffer slice.
package nn_pkg;

  localparam int N_DEFAULT = 10;
  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    SERVE = 2'd2
  } state_t;

endpackage

// File: rtl/buffer_bank.sv
// N x W register file: one write port, one registered read port.
// Reads past the last entry return zero rather than stale data.
module buffer_bank #(
  parameter int N  = 10,
  parameter int W  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [W-1:0] mem [N];

  // Storage is deliberately not reset; entries are simply overwritten.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_data <= '0;
    else if (re)
      rd_data <= (rd_addr <= LAST) ? mem[rd_addr] : '0;
  end

endmodule

// File: rtl/input_buffer.sv
// Collects N samples, pulses start, then serves indexed reads until done.
// Define INPUT_BUFFER_DBL_EN for ping-pong banks that keep filling while serving.
module input_buffer
  import nn_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_data,
  output logic                 in_ready,
  output logic                 start,
  input  logic                 read,
  input  logic [$clog2(N)-1:0] offset,
  output logic [W-1:0]         rd_data,
  input  logic                 done,
  output logic                 err
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t        state, state_nx;
  logic [AW-1:0] wr_cnt;
  logic          accept, wr_last, rd_en, spare_ready;

  assign accept  = in_valid && in_ready;
  assign wr_last = accept && (wr_cnt == LAST);
  assign rd_en   = (state == SERVE) && read;
  assign start   = (state == START);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FILL;
      wr_cnt <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (rd_en && (offset > LAST)) err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (wr_last) state_nx = START;
      START:   state_nx = SERVE;
      SERVE:   if (done) state_nx = spare_ready ? START : FILL;
      default: state_nx = FILL;
    endcase
  end

`ifdef INPUT_BUFFER_DBL_EN
  logic         wr_bank, rd_bank, rd_sel, spare_full, swap;
  logic [W-1:0] rd_data0, rd_data1;

  assign in_ready    = !spare_full;
  assign spare_ready = spare_full || wr_last;
  assign swap = ((state == FILL) && wr_last) ||
                ((state == SERVE) && done && spare_ready);

  // The bank being written is always the one not being served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_sel     <= 1'b0;
      spare_full <= 1'b0;
    end else begin
      if (swap) begin
        rd_bank    <= wr_bank;
        wr_bank    <= ~wr_bank;
        spare_full <= 1'b0;
      end else if (wr_last && (state != FILL)) begin
        spare_full <= 1'b1;
      end
      if (rd_en) rd_sel <= rd_bank;
    end
  end

  assign rd_data = rd_sel ? rd_data1 : rd_data0;

  buffer_bank #(.N(N), .W(W)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept && !wr_bank),
    .wr_addr (wr_cnt),
    .wr_data (in_data),
    .re      (rd_en && !rd_bank),
    .rd_addr (offset),
    .rd_data (rd_data0)
  );

  buffer_bank #(.N(N), .W(W)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept && wr_bank),
    .wr_addr (wr_cnt),
    .wr_data (in_data),
    .re      (rd_en && rd_bank),
    .rd_addr (offset),
    .rd_data (rd_data1)
  );
`else
  assign in_ready    = (state == FILL);
  assign spare_ready = 1'b0;

  buffer_bank #(.N(N), .W(W)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept),
    .wr_addr (wr_cnt),
    .wr_data (in_data),
    .re      (rd_en),
    .rd_addr (offset),
    .rd_data (rd_data)
  );
`endif

endmodule

// File: tb/tb_input_buffer.sv
// Randomised bench for input_buffer against a sample-list reference model,
// plus directed literal checks of the key scenarios.
module tb_input_buffer;

  localparam int N  = 10;
  localparam int W  = 8;
  localparam int AW = $clog2(N);
`ifdef INPUT_BUFFER_DBL_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          start;
  logic          read = 1'b0;
  logic [AW-1:0] offset = '0;
  logic [W-1:0]  rd_data;
  logic          done = 1'b0;
  logic          err;

  int checks = 0;
  int errors = 0;

  input_buffer #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .start    (start),
    .read     (read),
    .offset   (offset),
    .rd_data  (rd_data),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=collecting, 1=start pulse, 2=serving.
  int           m_phase = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_bank [2][N];
  int           m_wb = 0;
  int           m_rb = 0;
  bit           m_spare = 1'b0;
  logic [W-1:0] m_rd = '0;
  bit           m_err = 1'b0;
  bit           m_on = 1'b0;
  bit           m_acc, m_filled;

  function automatic bit exp_ready();
    return DBL ? !m_spare : (m_phase == 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit r,
                               input logic [AW-1:0] o, input bit dn);
    in_valid = v;
    in_data  = d;
    read     = r;
    offset   = o;
    done     = dn;
    cycle();
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_wb = 0; m_rb = 0;
      m_spare = 0; m_rd = '0; m_err = 0; m_on = 1;
    end else if (m_on) begin
      m_acc    = in_valid && exp_ready();
      m_filled = 1'b0;
      if (m_phase == 2 && read) begin
        if (int'(offset) < N) m_rd = m_bank[m_rb][offset];
        else begin m_rd = '0; m_err = 1'b1; end
      end
      if (m_acc) begin
        m_bank[m_wb][m_cnt] = in_data;
        m_cnt++;
        if (m_cnt == N) begin m_cnt = 0; m_filled = 1'b1; end
      end
      case (m_phase)
        0: if (m_filled) begin
             m_phase = 1; m_rb = m_wb; if (DBL) m_wb = 1 - m_wb;
           end
        1: begin m_phase = 2; if (m_filled) m_spare = 1'b1; end
        default:
          if (done) begin
            if (DBL && (m_spare || m_filled)) begin
              m_phase = 1; m_rb = m_wb; m_wb = 1 - m_wb; m_spare = 1'b0;
            end else m_phase = 0;
          end else if (m_filled) m_spare = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      checkOutput("model in_ready", 32'(in_ready), 32'(exp_ready()));
      checkOutput("model start", 32'(start), 32'(m_phase == 1));
      checkOutput("model rd_data", 32'(rd_data), 32'(m_rd));
      checkOutput("model err", 32'(err), 32'(m_err));
    end
  end

  initial begin
    rst_n = 1'b0;
    cycle();
    cycle();
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset start", 32'(start), 32'd0);
    checkOutput("reset rd_data", 32'(rd_data), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    rst_n = 1'b1;

    for (int i = 1; i <= 10; i++) begin
      if (i == 10) checkOutput("no early start", 32'(start), 32'd0);
      applyStimulus(1'b1, W'(i), 1'b0, '0, 1'b0);
    end
    in_valid = 1'b0;
    checkOutput("start after 10th", 32'(start), 32'd1);
    checkOutput("in_ready in start", 32'(in_ready), DBL ? 32'd1 : 32'd0);
    cycle();
    checkOutput("start one cycle", 32'(start), 32'd0);

    applyStimulus(1'b0, '0, 1'b1, 4'd3, 1'b0);
    checkOutput("read offset 3", 32'(rd_data), 32'd4);
    applyStimulus(1'b0, '0, 1'b0, 4'd7, 1'b0);
    checkOutput("rd_data holds", 32'(rd_data), 32'd4);

    applyStimulus(1'b0, '0, 1'b1, 4'd12, 1'b0);
    checkOutput("oob rd_data", 32'(rd_data), 32'd0);
    checkOutput("oob err", 32'(err), 32'd1);

    applyStimulus(1'b0, '0, 1'b1, 4'd9, 1'b1);
    checkOutput("read with done", 32'(rd_data), 32'd10);
    checkOutput("fill after done", 32'(in_ready), 32'd1);
    checkOutput("err sticky", 32'(err), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 4'd2, 1'b0);
    checkOutput("read ignored in fill", 32'(rd_data), 32'd10);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, W'(50 + i), 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    checkOutput("err cleared", 32'(err), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      checkOutput("no start mid refill", 32'(start), 32'd0);
      applyStimulus(1'b1, W'(100 + i), 1'b0, '0, 1'b0);
    end
    in_valid = 1'b0;
    checkOutput("start after reset refill", 32'(start), 32'd1);
    cycle();
    applyStimulus(1'b0, '0, 1'b1, 4'd0, 1'b0);
    checkOutput("refill entry 0", 32'(rd_data), 32'd101);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

`ifdef INPUT_BUFFER_DBL_EN
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) applyStimulus(1'b1, W'(i), 1'b0, '0, 1'b0);
    in_valid = 1'b0;
    checkOutput("dbl spare full", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("dbl second start", 32'(start), 32'd1);
    done = 1'b0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, '0, 1'b1, AW'(i), 1'b0);
      checkOutput("dbl second bank", 32'(rd_data), 32'(11 + i));
    end
`endif

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_buffer.md
INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 SHALL have parameter N, default 10: number of input samples per inference.
REQ-002 SHALL have parameter W, default 8: sample width in bits.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset; synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: upstream sample valid.
REQ-006 SHALL have port in_data  input  W: upstream sample.
REQ-007 SHALL have port in_ready  output  1: buffer can accept a sample this cycle.
REQ-008 SHALL have port start  output  1: one-cycle pulse to the downstream controller; buffer full.
REQ-009 SHALL have port read  input  1: controller read strobe.
REQ-010 SHALL have port offset  input  $clog2(N): sample index to read.
REQ-011 SHALL have port rd_data  output  W: registered sample at offset.
REQ-012 SHALL have port done  input  1: controller ready pulse; inference finished.
REQ-013 SHALL have port err  output  1: sticky out-of-range read flag.

Function
REQ-014 SHALL implement states FILL, START, SERVE.
REQ-015 FILL: in_ready=1; a sample SHALL be written at write index wr_cnt on in_valid&&in_ready, then wr_cnt increments.
REQ-016 The sample written at wr_cnt=N-1 SHALL move the FSM to START on the next edge; wr_cnt SHALL wrap to 0.
REQ-017 START: start=1 for exactly one cycle, in_ready=0; FSM SHALL go to SERVE unconditionally.
REQ-018 SERVE: on read=1, rd_data SHALL equal entry[offset] one cycle later; rd_data SHALL hold its value when read=0.
REQ-019 read with offset>=N SHALL give rd_data=0 next cycle and set err; err is cleared only by reset.
REQ-020 done=1 in SERVE SHALL return the FSM to FILL next cycle; done in FILL or START SHALL be ignored.
REQ-021 read and done in the same SERVE cycle: the read SHALL be served and the FSM SHALL still go to FILL.
REQ-022 read outside SERVE SHALL be ignored (rd_data holds).
REQ-023 Buffer contents SHALL NOT be cleared on return to FILL; entries are overwritten.

Reset
REQ-024 With rst_n=0 at a clock edge: state=FILL, wr_cnt=0, start=0, rd_data=0, err=0; in_ready=1 on the first cycle after reset.
REQ-025 Reset mid-FILL or mid-SERVE SHALL discard partial fill and the pending inference.

Configuration
REQ-026 Macro INPUT_BUFFER_DBL_EN SHALL enable ping-pong double buffering.
REQ-027 With the macro defined: two banks; in SERVE, the inactive bank SHALL accept samples (in_ready=1 until it is full). On done, if the inactive bank is full, banks SHALL swap and the FSM SHALL go to START directly; otherwise it SHALL go to FILL, continuing into the partially filled bank.
REQ-028 With the macro undefined: single bank; in_ready=0 in START and SERVE.

Structure
REQ-029 Package nn_pkg SHALL hold the state enum (FILL, START, SERVE) and default N/W constants.
REQ-030 Storage SHALL be a sub-module buffer_bank (N x W register file, one write port, one registered read port); the DBL build instantiates two.

Verification
REQ-031 Reset, then stream samples 1..10 back-to-back -> start high exactly on the cycle after the 10th sample is accepted; in_ready=0 in that cycle.
REQ-032 In SERVE, read with offset=3 -> rd_data=4 next cycle; drive read=0 -> rd_data stays 4.
REQ-033 read with offset=12 (N=10) -> rd_data=0 next cycle, err=1; err remains 1 after a later done.
REQ-034 read (offset=9) and done in the same cycle -> rd_data=10, and the FSM is in FILL with in_ready=1 next cycle.
REQ-035 Assert rst_n=0 after 5 samples, then stream 10 samples -> start occurs only after the 10th post-reset sample.
REQ-036 DBL build: stream 20 samples without stalls and pulse done after the first start -> second start pulses on the cycle after done, and reads return samples 11..20.
